// File: rtl/dbg_dump_uart.sv
// dbg_dump_uart
//   Streams a full snapshot of the processor state out of an 8N1 UART line.
//   A dump contains one header byte, then every register word, then every
//   data-memory word. Each word goes out as four bytes, most significant first.
//   Words are read through the register-file and data-memory display ports.
//   The core keeps running during a dump. Each word is frozen at the cycle
//   it is captured.
// Ports
//   CLK          rising-edge clock
//   Reset        asynchronous active-high reset
//   Start        dump request, accepted only while idle
//   DispReadReg  register index driven to the register-file display port
//   DispRegData  register word returned for DispReadReg
//   DispReadMem  word index driven to the data-memory display port
//   DispMemData  memory word returned for DispReadMem
//   TxD          UART serial output, idle high
//   Busy         high while a dump is in progress
//   Done         one-cycle pulse in the final cycle of a dump
module dbg_dump_uart #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          NREG         = 32,
  parameter int          NMEM         = 64,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  output logic [4:0]  DispReadReg,
  input  logic [31:0] DispRegData,
  output logic [5:0]  DispReadMem,
  input  logic [31:0] DispMemData,
  output logic        TxD,
  output logic        Busy,
  output logic        Done
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [6:0]        REG_LAST  = 7'(NREG - 1);
  localparam logic [6:0]        MEM_LAST  = 7'(NMEM - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    SETADDR = 3'd2,
    CAPTURE = 3'd3,
    SEND    = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t            stateR;
  state_t            stateNextS;
  logic [BAUD_W-1:0] baudCntR;
  logic [3:0]        bitCntR;
  logic [1:0]        byteCntR;
  logic [6:0]        idxR;
  logic              memPhaseR;
  // Remaining data bits of the current frame plus the stop bit.
  // Ones are shifted in behind the data, so the stop bit needs no extra logic.
  logic [8:0]        frameR;
  // The three bytes of the captured word that have not been framed yet.
  logic [23:0]       wordR;
  logic              txdR;
  logic              busyR;
  logic              doneR;
  logic [4:0]        regAddrR;
  logic [5:0]        memAddrR;

  logic              bitEndS;
  logic              frameEndS;
  logic              wordEndS;
  logic              lastIdxS;
  logic [31:0]       capDataS;

  assign TxD         = txdR;
  assign Busy        = busyR;
  assign Done        = doneR;
  assign DispReadReg = regAddrR;
  assign DispReadMem = memAddrR;

  // State register.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      stateR <= IDLE;
    end else begin
      stateR <= stateNextS;
    end
  end

  // Bit/frame/word strobes and next-state selection.
  always_comb begin
    bitEndS   = (baudCntR == BAUD_LAST);
    frameEndS = bitEndS && (bitCntR == 4'd9);
    wordEndS  = frameEndS && (byteCntR == 2'd3);
    if (memPhaseR) begin
      lastIdxS = (idxR == MEM_LAST);
      capDataS = DispMemData;
    end else begin
      lastIdxS = (idxR == REG_LAST);
      capDataS = DispRegData;
    end
    stateNextS = stateR;
    case (stateR)
      IDLE: begin
        if (Start) begin
          stateNextS = HDR;
        end else begin
          stateNextS = IDLE;
        end
      end
      HDR: begin
        if (frameEndS) begin
          stateNextS = SETADDR;
        end else begin
          stateNextS = HDR;
        end
      end
      SETADDR: stateNextS = CAPTURE;
      CAPTURE: stateNextS = SEND;
      SEND: begin
        if (wordEndS && lastIdxS && memPhaseR) begin
          stateNextS = FIN;
        end else if (wordEndS) begin
          stateNextS = SETADDR;
        end else begin
          stateNextS = SEND;
        end
      end
      FIN:     stateNextS = IDLE;
      default: stateNextS = IDLE;
    endcase
  end

  // Datapath: UART bit timing, word capture, index walk and registered outputs.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      baudCntR  <= '0;
      bitCntR   <= 4'd0;
      byteCntR  <= 2'd0;
      idxR      <= 7'd0;
      memPhaseR <= 1'b0;
      frameR    <= 9'h1FF;
      wordR     <= 24'd0;
      txdR      <= 1'b1;
      busyR     <= 1'b0;
      doneR     <= 1'b0;
      regAddrR  <= 5'd0;
      memAddrR  <= 6'd0;
    end else begin
      // Bit timing, shared by the header and the word bytes.
      // The frame-end actions are applied in the case below.
      if ((stateR == HDR) || (stateR == SEND)) begin
        if (bitEndS) begin
          baudCntR <= '0;
          if (bitCntR == 4'd9) begin
            bitCntR <= 4'd0;
          end else begin
            bitCntR <= bitCntR + 4'd1;
            txdR    <= frameR[0];
            frameR  <= {1'b1, frameR[8:1]};
          end
        end else begin
          baudCntR <= baudCntR + BAUD_W'(1);
        end
      end
      case (stateR)
        IDLE: begin
          doneR <= 1'b0;
          if (Start) begin
            busyR     <= 1'b1;
            txdR      <= 1'b0;
            frameR    <= {1'b1, HDR_BYTE};
            baudCntR  <= '0;
            bitCntR   <= 4'd0;
            byteCntR  <= 2'd0;
            idxR      <= 7'd0;
            memPhaseR <= 1'b0;
          end
        end
        HDR: begin
        end
        SETADDR: begin
          if (memPhaseR) begin
            memAddrR <= idxR[5:0];
          end else begin
            regAddrR <= idxR[4:0];
          end
        end
        CAPTURE: begin
          // Snapshot taken here; later core writes cannot affect this word.
          wordR    <= capDataS[23:0];
          frameR   <= {1'b1, capDataS[31:24]};
          txdR     <= 1'b0;
          baudCntR <= '0;
          bitCntR  <= 4'd0;
          byteCntR <= 2'd0;
        end
        SEND: begin
          if (frameEndS) begin
            if (byteCntR != 2'd3) begin
              // The next start bit follows the stop bit with no gap.
              byteCntR <= byteCntR + 2'd1;
              txdR     <= 1'b0;
              frameR   <= {1'b1, wordR[23:16]};
              wordR    <= {wordR[15:0], 8'h00};
            end else if (!lastIdxS) begin
              idxR <= idxR + 7'd1;
            end else if (!memPhaseR) begin
              memPhaseR <= 1'b1;
              idxR      <= 7'd0;
            end else begin
              doneR <= 1'b1;
            end
          end
        end
        FIN: begin
          doneR <= 1'b0;
          busyR <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_dump_uart.sv
`timescale 1ns/1ps
module tb_dbg_dump_uart;
  localparam int CPB      = 4;
  localparam int NREG     = 32;
  localparam int NMEM     = 64;
  // Cycle index, counted from the accepting edge, of the cycle in which Done is high.
  localparam int DONE_OFS = 15592;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  dispReadReg;
  logic [31:0] dispRegData;
  logic [5:0]  dispReadMem;
  logic [31:0] dispMemData;
  logic        txd;
  logic        busy;
  logic        done;

  logic [31:0] regs [NREG];
  logic [31:0] mems [NMEM];

  assign dispRegData = regs[dispReadReg];
  assign dispMemData = mems[dispReadMem];

  dbg_dump_uart #(
    .CLKS_PER_BIT(CPB),
    .NREG(NREG),
    .NMEM(NMEM),
    .HDR_BYTE(8'hA5)
  ) dut (
    .CLK(clk),
    .Reset(rst),
    .Start(start),
    .DispReadReg(dispReadReg),
    .DispRegData(dispRegData),
    .DispReadMem(dispReadMem),
    .DispMemData(dispMemData),
    .TxD(txd),
    .Busy(busy),
    .Done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [7:0] byteQ[$];
  int         doneQ[$];
  int         rxBytes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushDump();
    byteQ.push_back(8'hA5);
    for (int r = 0; r < NREG; r++)
      for (int b = 3; b >= 0; b--) byteQ.push_back(regs[r][8*b +: 8]);
    for (int m = 0; m < NMEM; m++)
      for (int b = 3; b >= 0; b--) byteQ.push_back(mems[m][8*b +: 8]);
  endtask

  task automatic doStart(input bit hold, output int acc);
    @(negedge clk);
    chk("busy_before_start", 32'(busy), 32'd0);
    start = 1'b1;
    @(negedge clk);
    acc = cyc;
    if (!hold) start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("hdr_start_bit", 32'(txd), 32'd0);
  endtask

  task automatic waitDoneQ(input int limit);
    int n = 0;
    while (doneQ.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (doneQ.size() != 0) begin
      chk("done_timeout", 32'(doneQ.size()), 32'd0);
      doneQ.delete();
    end
  endtask

  // Ideal UART receiver plus Done monitor; pops the scoreboard queues.
  initial begin
    bit         rxBusy = 1'b0;
    int         rxCnt = 0;
    logic [7:0] rxByte = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        rxBusy = 1'b0;
      end else begin
        if (done === 1'b1) begin
          chk("busy_at_done", 32'(busy), 32'd1);
          if (doneQ.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
          else chk("done_cycle", cyc, doneQ.pop_front());
        end
        if (!rxBusy) begin
          if (txd === 1'b0) begin
            rxBusy = 1'b1;
            rxCnt = 0;
          end
        end else begin
          rxCnt++;
          if (rxCnt == 2) begin
            chk("start_bit", 32'(txd), 32'd0);
          end else if (rxCnt >= 6 && rxCnt <= 34 && ((rxCnt - 6) % 4) == 0) begin
            rxByte[(rxCnt - 6) / 4] = txd;
          end else if (rxCnt == 38) begin
            chk("stop_bit", 32'(txd), 32'd1);
            if (byteQ.size() == 0) chk($sformatf("unexpected_byte%0d", rxBytes), 32'(rxByte), 32'hFFFF);
            else chk($sformatf("byte%0d", rxBytes), 32'(rxByte), 32'(byteQ.pop_front()));
            rxBytes++;
            rxBusy = 1'b0;
          end
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    int accA, accB, accC, dC, edges, n;
    logic prevTxd;
    for (int k = 0; k < NREG; k++) regs[k] = 32'(k) * 32'h01010101;
    for (int k = 0; k < NMEM; k++) mems[k] = 32'hC0DE0000 | 32'(k * 7 + 1);
    mems[0] = 32'h12345678;

    // Reset values, then quiet line without Start.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_readreg", 32'(dispReadReg), 32'd0);
    chk("rst_readmem", 32'(dispReadMem), 32'd0);
    rst = 1'b0;
    edges = 0;
    prevTxd = txd;
    repeat (100) begin
      @(negedge clk);
      if (txd !== prevTxd) edges++;
      prevTxd = txd;
    end
    chk("idle_edges", 32'(edges), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Dump A, with Start re-asserted mid-dump for 50 cycles (ignored).
    pushDump();
    doStart(1'b0, accA);
    doneQ.push_back(accA + DONE_OFS);
    repeat (5000) @(negedge clk);
    start = 1'b1;
    repeat (50) @(negedge clk);
    start = 1'b0;
    waitDoneQ(12000);
    repeat (5) @(negedge clk);
    chk("a_busy_low", 32'(busy), 32'd0);
    chk("a_queue_empty", 32'(byteQ.size()), 32'd0);
    chk("a_byte_count", 32'(rxBytes), 32'd385);

    // Dump B, reset in the 3rd data bit of byte 10 (reg2 byte 1 = 0x02, bit is 0).
    pushDump();
    doStart(1'b0, accB);
    repeat (419) @(negedge clk);
    chk("b_txd_before_rst", 32'(txd), 32'd0);
    chk("b_readreg_before_rst", 32'(dispReadReg), 32'd2);
    rst = 1'b1;
    #1;
    chk("b_rst_txd", 32'(txd), 32'd1);
    chk("b_rst_busy", 32'(busy), 32'd0);
    chk("b_rst_done", 32'(done), 32'd0);
    chk("b_rst_readreg", 32'(dispReadReg), 32'd0);
    byteQ.delete();
    repeat (3) @(negedge clk);
    chk("b_byte_count", 32'(rxBytes), 32'd395);
    rst = 1'b0;

    // Dumps C and D back to back with Start held; mem[5] written during its SEND in C.
    pushDump();
    doStart(1'b1, accC);
    doneQ.push_back(accC + DONE_OFS);
    doneQ.push_back(accC + 2 * DONE_OFS + 2);
    repeat (6086) @(negedge clk);
    chk("c_readmem_hold", 32'(dispReadMem), 32'd5);
    mems[5] = 32'hDEADBEEF;
    pushDump();
    n = 0;
    while (done !== 1'b1 && n < 12000) begin
      @(negedge clk);
      n++;
    end
    chk("c_done_seen", 32'(done), 32'd1);
    dC = cyc;
    @(negedge clk);
    chk("c_gap1_txd", 32'(txd), 32'd1);
    chk("c_gap1_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("d_hdr_start_txd", 32'(txd), 32'd0);
    chk("d_hdr_start_busy", 32'(busy), 32'd1);
    chk("d_hdr_gap", cyc - dC, 32'd2);
    start = 1'b0;
    waitDoneQ(20000);
    repeat (5) @(negedge clk);
    chk("d_busy_low", 32'(busy), 32'd0);
    chk("d_queue_empty", 32'(byteQ.size()), 32'd0);
    chk("d_byte_count", 32'(rxBytes), 32'd1165);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
